// File: rtl/alu_vec_pkg.sv
// Purpose: shared types and vector field layout for the ALU vector checker.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
// Vector layout, MSB to LSB: opcode(6) | funct(6) | a(WIDTH) | b(WIDTH) | ref(WIDTH).
package alu_vec_pkg;

   localparam int OPW = 6;
   localparam int FNW = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_APPLY,
      ST_WAIT,
      ST_CHECK,
      ST_DONE
   } state_t;

   function automatic int vec_w(input int width);
      return 3*width + OPW + FNW;
   endfunction

   function automatic int op_lsb(input int width);
      return 3*width + FNW;
   endfunction

   function automatic int fn_lsb(input int width);
      return 3*width;
   endfunction

   function automatic int a_lsb(input int width);
      return 2*width;
   endfunction

   function automatic int b_lsb(input int width);
      return width;
   endfunction

endpackage

// File: rtl/alu_vec_unpack.sv
// Purpose: split one packed test vector into its opcode/funct/a/b/ref fields.
// Latency: combinational, zero cycles.
// Backpressure: none; pure wiring.
// Ports: vec_data in; opcode, funct, a, b, ref_val out.
module alu_vec_unpack
   import alu_vec_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int VW    = vec_w(WIDTH)
)(
   input  logic [VW-1:0]    vec_data,
   output logic [OPW-1:0]   opcode,
   output logic [FNW-1:0]   funct,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] ref_val
);

   assign opcode  = vec_data[op_lsb(WIDTH) +: OPW];
   assign funct   = vec_data[fn_lsb(WIDTH) +: FNW];
   assign a       = vec_data[a_lsb(WIDTH)  +: WIDTH];
   assign b       = vec_data[b_lsb(WIDTH)  +: WIDTH];
   assign ref_val = vec_data[WIDTH-1:0];

endmodule

// File: rtl/alu_vector_checker.sv
// Purpose: replays stored vectors into an ALU under test and tallies pass/fail.
// Latency: LATENCY+3 cycles per vector (fetch, apply, wait LATENCY, check).
// Backpressure: none; start is ignored while busy, memory is read every fetch.
// Ports: clk/reset; start, stop_on_fail, num_vectors (run control);
//        vec_addr/vec_data (1-cycle read memory); opcode/funct/a/b -> ALU, dut_out <- ALU;
//        busy/done/pass, pass_count/fail_count, fail_index/fail_got/fail_exp (status).
module alu_vector_checker
   import alu_vec_pkg::*;
#(
   parameter  int WIDTH   = 32,
   parameter  int DEPTH   = 512,
   parameter  int LATENCY = 1,
   localparam int AW      = $clog2(DEPTH),
   localparam int VW      = vec_w(WIDTH)
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop_on_fail,
   input  logic [AW:0]      num_vectors,
   output logic [AW-1:0]    vec_addr,
   input  logic [VW-1:0]    vec_data,
   output logic [OPW-1:0]   opcode,
   output logic [FNW-1:0]   funct,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] dut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [AW:0]      pass_count,
   output logic [AW:0]      fail_count,
   output logic [AW-1:0]    fail_index,
   output logic [WIDTH-1:0] fail_got,
   output logic [WIDTH-1:0] fail_exp
);

   localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0] IDX_ONE   = AW'(1);
   localparam logic [3:0]    WAIT_LAST = 4'(LATENCY-1);

   state_t           state, state_nx;
   logic [AW-1:0]    idx;
   logic [AW:0]      cnt;
   logic [AW:0]      num_clamped;
   logic             stop_lat;
   logic [3:0]       wcnt;
   logic [WIDTH-1:0] ref_r;
   logic             match;
   logic             last_vec;

   logic [OPW-1:0]   u_opcode;
   logic [FNW-1:0]   u_funct;
   logic [WIDTH-1:0] u_a;
   logic [WIDTH-1:0] u_b;
   logic [WIDTH-1:0] u_ref;

   alu_vec_unpack #(.WIDTH(WIDTH)) u_unpack (
      .vec_data (vec_data),
      .opcode   (u_opcode),
      .funct    (u_funct),
      .a        (u_a),
      .b        (u_b),
      .ref_val  (u_ref)
   );

   // Requests beyond the memory size run the whole memory once; the index never wraps.
   assign num_clamped = (num_vectors > DEPTH_C) ? DEPTH_C : num_vectors;
   assign match       = (dut_out == ref_r);
   // cnt is at least 1 whenever CHECK is reachable, so cnt-1 cannot underflow here.
   assign last_vec    = ({1'b0, idx} == (cnt - CNT_ONE));

   assign vec_addr = idx;
   assign busy     = (state == ST_FETCH) || (state == ST_APPLY) ||
                     (state == ST_WAIT)  || (state == ST_CHECK);
   assign done     = (state == ST_DONE);
   assign pass     = done && (fail_count == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_nx = (num_clamped == '0) ? ST_DONE : ST_FETCH;
            end
         end
         ST_FETCH: state_nx = ST_APPLY;
         ST_APPLY: state_nx = ST_WAIT;
         // WAIT is always visited once; it lingers LATENCY-1 extra cycles so the
         // compare lands exactly LATENCY edges after the drive registers updated.
         ST_WAIT: begin
            if (wcnt == WAIT_LAST) begin
               state_nx = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if ((!match && stop_lat) || last_vec) begin
               state_nx = ST_DONE;
            end else begin
               state_nx = ST_FETCH;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx        <= '0;
         cnt        <= '0;
         stop_lat   <= 1'b0;
         wcnt       <= '0;
         ref_r      <= '0;
         opcode     <= '0;
         funct      <= '0;
         a          <= '0;
         b          <= '0;
         pass_count <= '0;
         fail_count <= '0;
         fail_index <= '0;
         fail_got   <= '0;
         fail_exp   <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  cnt        <= num_clamped;
                  stop_lat   <= stop_on_fail;
                  idx        <= '0;
                  pass_count <= '0;
                  fail_count <= '0;
                  fail_index <= '0;
                  fail_got   <= '0;
                  fail_exp   <= '0;
               end
            end
            ST_APPLY: begin
               opcode <= u_opcode;
               funct  <= u_funct;
               a      <= u_a;
               b      <= u_b;
               ref_r  <= u_ref;
               wcnt   <= '0;
            end
            ST_WAIT: begin
               wcnt <= wcnt + 4'd1;
            end
            ST_CHECK: begin
               if (match) begin
                  pass_count <= pass_count + CNT_ONE;
               end else begin
                  fail_count <= fail_count + CNT_ONE;
                  if (fail_count == '0) begin
                     fail_index <= idx;
                     fail_got   <= dut_out;
                     fail_exp   <= ref_r;
                  end
               end
               if (state_nx == ST_FETCH) begin
                  idx <= idx + IDX_ONE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_vector_checker.sv
// Purpose: self-checking bench for alu_vector_checker with memory and reference ALU models.
// Latency: instance A uses LATENCY=1/DEPTH=512, instance B uses LATENCY=4/DEPTH=16.
// Backpressure: n/a.
module tb_alu_vector_checker;

   localparam int W   = 32;
   localparam int VW  = 3*W + 12;
   localparam int DA  = 512;
   localparam int AWA = 9;
   localparam int DB  = 16;
   localparam int AWB = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance A signals
   logic           rst_a, start_a, stop_a;
   logic [AWA:0]   num_a;
   logic [AWA-1:0] addr_a;
   logic [VW-1:0]  vdat_a;
   logic [5:0]     op_a, fn_a;
   logic [W-1:0]   a_a, b_a, dout_a;
   logic           busy_a, done_a, pass_a;
   logic [AWA:0]   pc_a, fc_a;
   logic [AWA-1:0] fidx_a;
   logic [W-1:0]   fgot_a, fexp_a;

   // instance B signals
   logic           rst_b, start_b, stop_b;
   logic [AWB:0]   num_b;
   logic [AWB-1:0] addr_b;
   logic [VW-1:0]  vdat_b;
   logic [5:0]     op_b, fn_b;
   logic [W-1:0]   a_b, b_b, dout_b;
   logic           busy_b, done_b, pass_b;
   logic [AWB:0]   pc_b, fc_b;
   logic [AWB-1:0] fidx_b;
   logic [W-1:0]   fgot_b, fexp_b;

   logic [VW-1:0] mem  [DA];
   logic [VW-1:0] gold [DA];
   logic [W-1:0]  pipe_b [4];

   int total = 0;
   int bad   = 0;

   alu_vector_checker #(.WIDTH(W), .DEPTH(DA), .LATENCY(1)) dut_a (
      .clk(clk), .reset(rst_a), .start(start_a), .stop_on_fail(stop_a),
      .num_vectors(num_a), .vec_addr(addr_a), .vec_data(vdat_a),
      .opcode(op_a), .funct(fn_a), .a(a_a), .b(b_a), .dut_out(dout_a),
      .busy(busy_a), .done(done_a), .pass(pass_a),
      .pass_count(pc_a), .fail_count(fc_a),
      .fail_index(fidx_a), .fail_got(fgot_a), .fail_exp(fexp_a)
   );

   alu_vector_checker #(.WIDTH(W), .DEPTH(DB), .LATENCY(4)) dut_b (
      .clk(clk), .reset(rst_b), .start(start_b), .stop_on_fail(stop_b),
      .num_vectors(num_b), .vec_addr(addr_b), .vec_data(vdat_b),
      .opcode(op_b), .funct(fn_b), .a(a_b), .b(b_b), .dut_out(dout_b),
      .busy(busy_b), .done(done_b), .pass(pass_b),
      .pass_count(pc_b), .fail_count(fc_b),
      .fail_index(fidx_b), .fail_got(fgot_b), .fail_exp(fexp_b)
   );

   // Reference ALU: opcode 0 is R-type selected by funct, opcode 0x0F is LUI.
   function automatic logic [W-1:0] alu(input logic [5:0] op, input logic [5:0] fn,
                                        input logic [W-1:0] x, input logic [W-1:0] y);
      if (op == 6'h0f) return {y[15:0], 16'h0000};
      if (op != 6'h00) return '0;
      case (fn)
         6'h21:   return x + y;
         6'h23:   return x - y;
         6'h24:   return x & y;
         6'h25:   return x | y;
         6'h26:   return x ^ y;
         default: return '0;
      endcase
   endfunction

   // 1-cycle read memories and the ALUs under test
   always @(posedge clk) vdat_a <= mem[int'(addr_a)];
   always @(posedge clk) vdat_b <= mem[int'(addr_b)];
   always @(posedge clk) dout_a <= alu(op_a, fn_a, a_a, b_a);
   always @(posedge clk) begin
      pipe_b[0] <= alu(op_b, fn_b, a_b, b_b);
      for (int i = 1; i < 4; i++) pipe_b[i] <= pipe_b[i-1];
   end
   assign dout_b = pipe_b[3];

   function automatic logic [VW-1:0] mk(input int i);
      logic [5:0] op, fn;
      logic [W-1:0] x, y, r;
      case (i)
         0: begin op = 6'h00; fn = 6'h21; x = 32'h7FFFFFFF; y = 32'h00000001; r = 32'h80000000; end
         1: begin op = 6'h00; fn = 6'h23; x = 32'h00000005; y = 32'h00000007; r = 32'hFFFFFFFE; end
         2: begin op = 6'h00; fn = 6'h24; x = 32'hF0F0F0F0; y = 32'h0FF00FF0; r = 32'h00F000F0; end
         3: begin op = 6'h00; fn = 6'h25; x = 32'h12340000; y = 32'h00005678; r = 32'h12345678; end
         4: begin op = 6'h00; fn = 6'h26; x = 32'hFFFF0000; y = 32'hFF00FF00; r = 32'h00FFFF00; end
         5: begin op = 6'h0F; fn = 6'h00; x = 32'h00000000; y = 32'h0000ABCD; r = 32'hABCD0000; end
         default: begin
            op = 6'h00;
            case (i % 5)
               0: fn = 6'h21;
               1: fn = 6'h23;
               2: fn = 6'h24;
               3: fn = 6'h25;
               default: fn = 6'h26;
            endcase
            x = 32'(i) * 32'h9E3779B1;
            y = 32'(i) * 32'h01000193 + 32'd7;
            r = alu(op, fn, x, y);
         end
      endcase
      return {op, fn, x, y, r};
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, got, exp);
      end
   endtask

   typedef struct {
      logic [AWA:0] num;
      bit           stop;
      int           bad0;
      int           bad1;
      bit           poke;
      int           exp_cyc;
      int           exp_pc;
      int           exp_fc;
      int           exp_fidx;
      bit           exp_pass;
      logic [W-1:0] exp_fexp;
      logic [W-1:0] exp_fgot;
   } run_t;

   task automatic run_a(input int k, input run_t r);
      int cyc;
      for (int i = 0; i < DA; i++) mem[i] = gold[i];
      if (r.bad0 >= 0) mem[r.bad0][W-1:0] = 32'hDEADBEEF;
      if (r.bad1 >= 0) mem[r.bad1][W-1:0] = 32'hDEADBEEF;
      @(negedge clk);
      start_a = 1'b1; num_a = r.num; stop_a = r.stop;
      @(posedge clk); #1;
      start_a = 1'b0;
      cyc = 1;
      chk($sformatf("run%0d busy", k), 64'(busy_a), 64'(r.num != 0));
      while (!done_a && cyc < 3000) begin
         // start pulse during a run must be ignored
         if (r.poke && cyc == 5) begin
            start_a = 1'b1; num_a = '0;
         end
         @(posedge clk); #1;
         start_a = 1'b0;
         cyc++;
      end
      chk($sformatf("run%0d cycles", k), 64'(cyc), 64'(r.exp_cyc));
      chk($sformatf("run%0d done", k), 64'(done_a), 64'd1);
      chk($sformatf("run%0d busy_end", k), 64'(busy_a), 64'd0);
      chk($sformatf("run%0d pass", k), 64'(pass_a), 64'(r.exp_pass));
      chk($sformatf("run%0d pass_count", k), 64'(pc_a), 64'(r.exp_pc));
      chk($sformatf("run%0d fail_count", k), 64'(fc_a), 64'(r.exp_fc));
      chk($sformatf("run%0d fail_index", k), 64'(fidx_a), 64'(r.exp_fidx));
      chk($sformatf("run%0d fail_exp", k), 64'(fexp_a), 64'(r.exp_fexp));
      chk($sformatf("run%0d fail_got", k), 64'(fgot_a), 64'(r.exp_fgot));
   endtask

   run_t sc [5];

   initial begin
      int cyc;
      sc[0] = '{num: 10'd4,   stop: 1'b0, bad0: -1, bad1: -1, poke: 1'b1, exp_cyc: 17,
                exp_pc: 4,   exp_fc: 0, exp_fidx: 0, exp_pass: 1'b1,
                exp_fexp: 32'h0, exp_fgot: 32'h0};
      sc[1] = '{num: 10'd4,   stop: 1'b1, bad0: 2,  bad1: -1, poke: 1'b0, exp_cyc: 13,
                exp_pc: 2,   exp_fc: 1, exp_fidx: 2, exp_pass: 1'b0,
                exp_fexp: 32'hDEADBEEF, exp_fgot: 32'h00F000F0};
      sc[2] = '{num: 10'd5,   stop: 1'b0, bad0: 1,  bad1: 3,  poke: 1'b0, exp_cyc: 21,
                exp_pc: 3,   exp_fc: 2, exp_fidx: 1, exp_pass: 1'b0,
                exp_fexp: 32'hDEADBEEF, exp_fgot: 32'hFFFFFFFE};
      sc[3] = '{num: 10'd0,   stop: 1'b0, bad0: -1, bad1: -1, poke: 1'b0, exp_cyc: 1,
                exp_pc: 0,   exp_fc: 0, exp_fidx: 0, exp_pass: 1'b1,
                exp_fexp: 32'h0, exp_fgot: 32'h0};
      sc[4] = '{num: 10'd517, stop: 1'b0, bad0: -1, bad1: -1, poke: 1'b0, exp_cyc: 2049,
                exp_pc: 512, exp_fc: 0, exp_fidx: 0, exp_pass: 1'b1,
                exp_fexp: 32'h0, exp_fgot: 32'h0};

      for (int i = 0; i < DA; i++) begin
         gold[i] = mk(i);
         mem[i]  = gold[i];
      end
      rst_a = 1'b1; start_a = 1'b0; stop_a = 1'b0; num_a = '0;
      rst_b = 1'b1; start_b = 1'b0; stop_b = 1'b0; num_b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", 64'(busy_a), 64'd0);
      chk("reset done", 64'(done_a), 64'd0);
      chk("reset pass", 64'(pass_a), 64'd0);
      chk("reset vec_addr", 64'(addr_a), 64'd0);
      chk("reset drives", 64'({op_a, fn_a, a_a, b_a} != '0), 64'd0);
      chk("reset counts", 64'({pc_a, fc_a}), 64'd0);
      chk("reset fail fields", 64'({fidx_a, fgot_a, fexp_a} != '0), 64'd0);
      @(negedge clk);
      rst_a = 1'b0; rst_b = 1'b0;

      for (int k = 0; k < 5; k++) begin
         run_a(k, sc[k]);
         if (k == 0) begin
            // drives hold vector 3 after DONE
            chk("hold opcode", 64'(op_a), 64'h00);
            chk("hold funct", 64'(fn_a), 64'h25);
            chk("hold a", 64'(a_a), 64'h12340000);
            chk("hold b", 64'(b_a), 64'h00005678);
         end
      end

      // Instance B: reset in WAIT of vector 3 (period 7 cycles at LATENCY=4)
      @(negedge clk);
      start_b = 1'b1; num_b = 5'd6; stop_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      cyc = 1;
      while (cyc < 25) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("B busy before reset", 64'(busy_b), 64'd1);
      chk("B pass_count before reset", 64'(pc_b), 64'd3);
      chk("B vec_addr before reset", 64'(addr_b), 64'd3);
      rst_b = 1'b1;
      @(posedge clk); #1;
      rst_b = 1'b0;
      chk("B reset status", 64'({busy_b, done_b, pass_b}), 64'd0);
      chk("B reset vec_addr", 64'(addr_b), 64'd0);
      chk("B reset drives", 64'({op_b, fn_b, a_b, b_b} != '0), 64'd0);
      chk("B reset counts", 64'({pc_b, fc_b}), 64'd0);
      chk("B reset fail fields", 64'({fidx_b, fgot_b, fexp_b} != '0), 64'd0);

      @(negedge clk);
      start_b = 1'b1; num_b = 5'd6; stop_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      cyc = 1;
      while (!done_b && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("B rerun cycles", 64'(cyc), 64'd43);
      chk("B rerun pass_count", 64'(pc_b), 64'd6);
      chk("B rerun fail_count", 64'(fc_b), 64'd0);
      chk("B rerun pass", 64'(pass_b), 64'd1);
      chk("B rerun last drive b", 64'(b_b), 64'h0000ABCD);

      // reset wins over start in the same cycle
      @(negedge clk);
      rst_b = 1'b1; start_b = 1'b1; num_b = 5'd2;
      @(posedge clk); #1;
      rst_b = 1'b0; start_b = 1'b0;
      @(posedge clk); #1;
      chk("B reset over start status", 64'({busy_b, done_b, pass_b}), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_vector_checker.md
ALU_VECTOR_CHECKER -- requirements
Module: alu_vector_checker

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 512, vector memory entries; AW = clog2(DEPTH).
REQ-003 The module SHALL have parameter LATENCY, default 1, range 1..15, cycles from operand drive to result sample.
REQ-004 The module SHALL have vector width VW = 3*WIDTH+12 (default 108), laid out as opcode[VW-1:VW-6], funct[VW-7:VW-12], A, B, REF from MSB to LSB.
REQ-005 The module SHALL use one clock and a synchronous, active-high reset: Clock input 1, rising-edge clock; Reset input 1, synchronous active-high reset.
REQ-006 Start input 1: one-cycle pulse begins a run.
REQ-007 StopOnFail input 1: sampled at Start; 1 = halt at first mismatch, 0 = run all vectors.
REQ-008 NumVectors input AW+1: vectors to run, sampled at Start.
REQ-009 VecAddr output AW: vector memory read address.
REQ-010 VecData input VW: memory read data, valid exactly 1 cycle after VecAddr.
REQ-011 Opcode output 6, Funct output 6, A output WIDTH, B output WIDTH: registered drive to decoder/ALU under test.
REQ-012 DUTout input WIDTH: result from ALU under test.
REQ-013 Busy output 1, Done output 1, Pass output 1: run status.
REQ-014 PassCount output AW+1, FailCount output AW+1: per-run tallies.
REQ-015 FailIndex output AW, FailGot output WIDTH, FailExp output WIDTH: captured first mismatch.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, APPLY, WAIT, CHECK, DONE.
REQ-017 IDLE: Start=1 SHALL latch NumVectors (clamped to DEPTH) and StopOnFail, clear counters, Done, FailIndex/FailGot/FailExp, set index 0, go FETCH; Start=0 stays IDLE.
REQ-018 If latched count is 0, IDLE SHALL go directly to DONE with Pass=1.
REQ-019 FETCH: VecAddr SHALL equal index; next state APPLY (one cycle).
REQ-020 APPLY: Opcode/Funct/A/B and internal REF register SHALL load from VecData fields at end of cycle; next WAIT.
REQ-021 WAIT: SHALL hold LATENCY-1 cycles (zero when LATENCY=1), then CHECK; DUTout is compared in CHECK, exactly LATENCY cycles after drive update.
REQ-022 CHECK: DUTout==REF SHALL increment PassCount; else increment FailCount and, if it is the first failure, capture index, DUTout, REF.
REQ-023 CHECK exit: mismatch with StopOnFail=1, or index = count-1, SHALL go DONE; otherwise index increments and FETCH.
REQ-024 Per-vector period SHALL be LATENCY+3 cycles.
REQ-025 DONE: Done=1, Pass=(FailCount==0), Busy=0; Start SHALL begin a new run as in IDLE; otherwise hold.
REQ-026 Busy SHALL be 1 in FETCH/APPLY/WAIT/CHECK; Start while Busy SHALL be ignored.
REQ-027 Drive outputs SHALL hold last applied values between vectors and after DONE.
REQ-028 Counters cannot overflow (max DEPTH fits AW+1 bits); index SHALL not wrap.

Reset
REQ-029 Reset SHALL force IDLE; all outputs 0, including VecAddr, drive outputs, counters, Fail* and Done/Pass/Busy.
REQ-030 Reset asserted mid-run SHALL abort at the next edge without completing CHECK; no partial count update.
REQ-031 Reset SHALL dominate Start in the same cycle.

Structure
REQ-032 Package alu_vec_pkg SHALL hold state enum, opcode/funct widths (6), and field-offset functions of WIDTH.
REQ-033 Sub-module alu_vec_unpack (combinational field split of VecData) SHALL be the only child; FSM, counters and capture stay in the top.

Verification
REQ-034 Bench SHALL model vector memory with 1-cycle read and a reference ALU/decoder as DUT.
REQ-035 All-pass: 4 vectors incl. ADDU 0x7FFFFFFF+0x1=0x80000000, LATENCY=1 -> Done after 4*4+1 cycles, PassCount=4, FailCount=0, Pass=1.
REQ-036 StopOnFail=1, vector 2 REF corrupted to 0xDEADBEEF -> Done after vector 2, PassCount=2, FailCount=1, FailIndex=2, FailExp=0xDEADBEEF.
REQ-037 StopOnFail=0, vectors 1 and 3 corrupted of 5 -> PassCount=3, FailCount=2, FailIndex=1, Pass=0.
REQ-038 NumVectors=0 -> Done=1, Pass=1 one cycle after Start; NumVectors=DEPTH+5 -> runs DEPTH vectors.
REQ-039 Reset pulsed in WAIT of vector 3, LATENCY=4 -> all outputs 0 next cycle; subsequent Start reruns from index 0.
